simt_regfile_sb: RTL

//  Parametrised per-lane register file for one SIMT core: NUM_THREADS lanes, each with
//  NUM_REGS-3 general-purpose registers plus 3 read-only specials (block id, threads/block,

---
 rtl/simt_regfile_sb.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/simt_regfile_sb.sv
// ----------------------------------------------------------------------------
// simt_regfile_sb
//   Per-lane register file for one SIMT core. Every lane holds NUM_REGS-3
//   general-purpose registers; the top three addresses are read-only specials
//   (block id, threads per block, thread id). Two registered read ports share
//   one address across all lanes. An ALU write port and an LSU write-back port
//   write per lane by mask, with the LSU taking priority on a collision. A
//   scoreboard of pending loads (one bit per GPR, shared by all lanes) drives
//   a combinational hazard flag toward the scheduler/decoder.
//
// Optional feature macro: SIMT_REGFILE_BYPASS_EN
//   defined   : write-first reads (a same-cycle write to the read lane+reg is
//               returned, LSU over ALU) and a same-cycle pending clear
//               suppresses rd_hazard.
//   undefined : read-first reads (old register value) and rd_hazard uses the
//               pending bits as they stand before the clock edge.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   rd_en, rd_addr1/2      read request, addresses shared by all lanes
//   rd_valid, rd_data1/2   registered read result (lane i at [i*DATA_W +: DATA_W])
//   rd_hazard              comb: a requested read address has a pending load
//   alu_we/waddr/wdata     ALU write port, per-lane enable
//   ld_issue, ld_issue_rd  load issued: mark destination pending
//   ld_we/waddr/wdata      LSU write-back port, per-lane enable, clears pending
//   wr_conflict            registered pulse: ALU and LSU hit the same lane+reg
//   block_id, threads_per_block, thread_base   live values for the specials
// ----------------------------------------------------------------------------
module simt_regfile_sb #(
    parameter  int unsigned DATA_W      = 8,
    parameter  int unsigned NUM_THREADS = 4,
    parameter  int unsigned NUM_REGS    = 16,
    localparam int unsigned ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr1,
    input  logic [ADDR_W-1:0]             rd_addr2,
    output logic                          rd_valid,
    output logic [NUM_THREADS*DATA_W-1:0] rd_data1,
    output logic [NUM_THREADS*DATA_W-1:0] rd_data2,
    output logic                          rd_hazard,

    input  logic [NUM_THREADS-1:0]        alu_we,
    input  logic [ADDR_W-1:0]             alu_waddr,
    input  logic [NUM_THREADS*DATA_W-1:0] alu_wdata,

    input  logic                          ld_issue,
    input  logic [ADDR_W-1:0]             ld_issue_rd,
    input  logic [NUM_THREADS-1:0]        ld_we,
    input  logic [ADDR_W-1:0]             ld_waddr,
    input  logic [NUM_THREADS*DATA_W-1:0] ld_wdata,
    output logic                          wr_conflict,

    input  logic [DATA_W-1:0]             block_id,
    input  logic [DATA_W-1:0]             threads_per_block,
    input  logic [DATA_W-1:0]             thread_base
);

    localparam int unsigned NUM_GPR = NUM_REGS - 3;
    localparam int unsigned BUS_W   = NUM_THREADS * DATA_W;

    // Special register addresses; everything below REG_BID is a GPR.
    localparam logic [ADDR_W-1:0] REG_BID = ADDR_W'(NUM_REGS - 3);
    localparam logic [ADDR_W-1:0] REG_TPB = ADDR_W'(NUM_REGS - 2);
    localparam logic [ADDR_W-1:0] REG_TID = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0]  gpr_q  [NUM_THREADS][NUM_GPR];
    logic [DATA_W-1:0]  gpr_d  [NUM_THREADS][NUM_GPR];
    logic [DATA_W-1:0]  rd_src [NUM_THREADS][NUM_GPR];

    logic [NUM_GPR-1:0] pending_q, pending_d;
    logic [NUM_GPR-1:0] pend_set, pend_clr, pend_view;

    logic               rd_valid_q, rd_valid_d;
    logic [BUS_W-1:0]   rd_data1_q, rd_data1_d;
    logic [BUS_W-1:0]   rd_data2_q, rd_data2_d;
    logic               wr_conflict_q, wr_conflict_d;

    function automatic logic in_gpr(input logic [ADDR_W-1:0] a);
        return a < REG_BID;
    endfunction

    function automatic logic pend_at(input logic [NUM_GPR-1:0] view,
                                     input logic [ADDR_W-1:0]  a);
        logic hit;
        hit = 1'b0;
        if (in_gpr(a)) begin
            hit = view[a];
        end
        return hit;
    endfunction

    // Lane read mux: GPR value or one of the live special inputs.
    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] gpr_val,
                                                   input logic [DATA_W-1:0] tid,
                                                   input logic [DATA_W-1:0] bid,
                                                   input logic [DATA_W-1:0] tpb);
        logic [DATA_W-1:0] v;
        v = '0;
        if (in_gpr(a)) begin
            v = gpr_val;
        end else if (a == REG_BID) begin
            v = bid;
        end else if (a == REG_TPB) begin
            v = tpb;
        end else if (a == REG_TID) begin
            v = tid;
        end
        return v;
    endfunction

    // Register writes: ALU first, LSU overrides on the same lane+reg.
    always_comb begin
        gpr_d = gpr_q;
        for (int l = 0; l < int'(NUM_THREADS); l++) begin
            if (alu_we[l] && in_gpr(alu_waddr)) begin
                gpr_d[l][alu_waddr] = alu_wdata[l*DATA_W +: DATA_W];
            end
            if (ld_we[l] && in_gpr(ld_waddr)) begin
                gpr_d[l][ld_waddr] = ld_wdata[l*DATA_W +: DATA_W];
            end
        end
    end

    // Collision only matters when both ports would actually write a GPR.
    always_comb begin
        wr_conflict_d = in_gpr(alu_waddr) && (alu_waddr == ld_waddr) &&
                        ((alu_we & ld_we) != '0);
    end

    // Scoreboard: a load issue in the same cycle as its write-back stays pending.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (ld_issue && in_gpr(ld_issue_rd)) begin
            pend_set[ld_issue_rd] = 1'b1;
        end
        if ((ld_we != '0) && in_gpr(ld_waddr)) begin
            pend_clr[ld_waddr] = 1'b1;
        end
        pending_d = (pending_q & ~pend_clr) | pend_set;
    end

    // Read source and hazard view depend on the bypass build option.
    always_comb begin
`ifdef SIMT_REGFILE_BYPASS_EN
        rd_src    = gpr_d;
        pend_view = pending_q & ~pend_clr;
`else
        rd_src    = gpr_q;
        pend_view = pending_q;
`endif
    end

    always_comb begin
        rd_hazard = rd_en && (pend_at(pend_view, rd_addr1) || pend_at(pend_view, rd_addr2));
    end

    // Read ports: sample on rd_en, otherwise hold the last result.
    always_comb begin
        logic [DATA_W-1:0] g1;
        logic [DATA_W-1:0] g2;
        logic [DATA_W-1:0] tid;
        g1         = '0;
        g2         = '0;
        tid        = '0;
        rd_valid_d = rd_en;
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        if (rd_en) begin
            for (int l = 0; l < int'(NUM_THREADS); l++) begin
                g1  = in_gpr(rd_addr1) ? rd_src[l][rd_addr1] : '0;
                g2  = in_gpr(rd_addr2) ? rd_src[l][rd_addr2] : '0;
                // Thread id wraps at DATA_W bits.
                tid = DATA_W'(thread_base + DATA_W'(l));
                rd_data1_d[l*DATA_W +: DATA_W] =
                    read_mux(rd_addr1, g1, tid, block_id, threads_per_block);
                rd_data2_d[l*DATA_W +: DATA_W] =
                    read_mux(rd_addr2, g2, tid, block_id, threads_per_block);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpr_q         <= '{default: '0};
            pending_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_data1_q    <= '0;
            rd_data2_q    <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            gpr_q         <= gpr_d;
            pending_q     <= pending_d;
            rd_valid_q    <= rd_valid_d;
            rd_data1_q    <= rd_data1_d;
            rd_data2_q    <= rd_data2_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data1    = rd_data1_q;
    assign rd_data2    = rd_data2_q;
    assign wr_conflict = wr_conflict_q;

endmodule
